// File: rtl/tea_boot_loader_pkg.sv
// Shared definitions for the tea_cpu boot loader: word/checksum widths,
// FSM state encoding and the frame length bound check.
package tea_boot_loader_pkg;

  localparam int INSTR_WIDTH = 9;
  localparam int CSUM_WIDTH  = 8;
  localparam int LEN_WIDTH   = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CSUM,
    ST_RELEASE,
    ST_RUN,
    ST_ERROR
  } state_t;

  // An image must hold at least one word and fit the instruction address space.
  function automatic logic len_ok(input logic [LEN_WIDTH-1:0] n, input int pc_w);
    return (n != '0) && (32'(n) <= (32'd1 << pc_w));
  endfunction

endpackage

// File: rtl/tea_boot_loader.sv
// Boot sequencer for tea_cpu: holds the CPU in reset, receives a framed image
// over a byte stream, writes 9-bit words to instruction RAM, checks the sum, releases reset.
module tea_boot_loader
  import tea_boot_loader_pkg::*;
#(
  parameter int PC_WIDTH    = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_data,
  output logic                   imem_we,
  output logic [PC_WIDTH-1:0]    imem_waddr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t                 state;
  logic [LEN_WIDTH-1:0]   len;
  logic [7:0]             lo_byte;
  logic [PC_WIDTH-1:0]    idx;
  logic [CSUM_WIDTH-1:0]  sum;
  logic [HW-1:0]          hold_cnt;

  logic                   accept;
  logic [CSUM_WIDTH-1:0]  sum_nxt;
  logic                   last_word;

  assign accept    = s_valid && s_ready;
  assign sum_nxt   = sum + s_data;
  assign last_word = (LEN_WIDTH'(idx) + LEN_WIDTH'(1)) == len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      len        <= '0;
      lo_byte    <= '0;
      idx        <= '0;
      sum        <= '0;
      hold_cnt   <= '0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        // s_ready is low in these states, so a byte offered alongside start is left alone.
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (start) begin
            state   <= ST_LEN_LO;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            cpu_rst <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            sum     <= '0;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len[7:0] <= s_data;
            sum      <= sum_nxt;
            state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len[15:8] <= s_data;
            sum       <= sum_nxt;
            idx       <= '0;
            if (len_ok({s_data, len[7:0]}, PC_WIDTH)) begin
              state <= ST_DATA_LO;
            end else begin
              state   <= ST_ERROR;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              err     <= 1'b1;
            end
          end
        end
        ST_DATA_LO: begin
          if (accept) begin
            lo_byte <= s_data;
            sum     <= sum_nxt;
            state   <= ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          if (accept) begin
            sum        <= sum_nxt;
            imem_we    <= 1'b1;
            imem_waddr <= idx;
            imem_wdata <= {s_data[0], lo_byte};
            // idx stops at the last word so a full-size image never wraps it.
            if (last_word) begin
              state <= ST_CSUM;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_DATA_LO;
            end
          end
        end
        ST_CSUM: begin
          if (accept) begin
            s_ready <= 1'b0;
            if (sum_nxt == '0) begin
              state    <= ST_RELEASE;
              hold_cnt <= '0;
            end else begin
              state <= ST_ERROR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
        // Entered on the CSUM edge; the HOLD_CYCLES-th edge after it releases the CPU.
        ST_RELEASE: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state   <= ST_RUN;
            cpu_rst <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_boot_loader.sv
// Directed bench for tea_boot_loader: frame table plus hand sequences for
// release timing, stream gaps and asynchronous reset mid-load.
module tb_tea_boot_loader;

  localparam int PC_WIDTH    = 10;
  localparam int HOLD_CYCLES = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [7:0]          s_data = 8'h00;
  logic                imem_we;
  logic [PC_WIDTH-1:0] imem_waddr;
  logic [8:0]          imem_wdata;
  logic                cpu_rst, busy, done, err;

  tea_boot_loader #(.PC_WIDTH(PC_WIDTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [18:0] wq[$];

  always @(negedge clk) if (imem_we) wq.push_back({imem_waddr, imem_wdata});

  typedef struct {
    int               nb;
    logic [0:11][7:0] b;
    int               nwr;
    logic [0:2][8:0]  wd;
    bit               exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("byte_accept_timeout", 32'(n), 32'd0);
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id, input bit gaps);
    wq.delete();
    pulse_start();
    chk($sformatf("v%0d_busy_after_start", id), 32'(busy), 32'd1);
    chk($sformatf("v%0d_cpu_rst_after_start", id), 32'(cpu_rst), 32'd1);
    chk($sformatf("v%0d_err_cleared", id), 32'(err), 32'd0);
    for (int k = 0; k < v.nb; k++) send_byte(v.b[k], gaps);
    chk($sformatf("v%0d_s_ready_low", id), 32'(s_ready), 32'd0);
    if (v.exp_err) begin
      chk($sformatf("v%0d_err", id), 32'(err), 32'd1);
      chk($sformatf("v%0d_done", id), 32'(done), 32'd0);
      chk($sformatf("v%0d_cpu_rst", id), 32'(cpu_rst), 32'd1);
      chk($sformatf("v%0d_busy", id), 32'(busy), 32'd0);
    end else begin
      for (int t = 1; t <= HOLD_CYCLES; t++) begin
        @(negedge clk);
        chk($sformatf("v%0d_cpu_rst_t%0d", id, t), 32'(cpu_rst), (t < HOLD_CYCLES) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d_done_t%0d", id, t), 32'(done), (t < HOLD_CYCLES) ? 32'd0 : 32'd1);
      end
      chk($sformatf("v%0d_err_clear", id), 32'(err), 32'd0);
    end
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_write_count", id), 32'(wq.size()), 32'(v.nwr));
    for (int j = 0; j < v.nwr && j < wq.size(); j++)
      chk($sformatf("v%0d_write%0d", id, j), 32'(wq[j]), 32'({10'(j), v.wd[j]}));
  endtask

  initial begin
    vecs[0] = '{nb: 9, b: {8'h03, 8'h00, 8'h5A, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01, 8'h6E, 8'h00, 8'h00, 8'h00},
                nwr: 3, wd: {9'h15A, 9'h034, 9'h1FF}, exp_err: 1'b0};
    vecs[1] = '{nb: 9, b: {8'h03, 8'h00, 8'h5A, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01, 8'h6F, 8'h00, 8'h00, 8'h00},
                nwr: 3, wd: {9'h15A, 9'h034, 9'h1FF}, exp_err: 1'b1};
    vecs[2] = vecs[0];
    vecs[3] = '{nb: 2, b: {8'h00, 8'h00, 80'h0}, nwr: 0, wd: '0, exp_err: 1'b1};
    vecs[4] = '{nb: 2, b: {8'h01, 8'h04, 80'h0}, nwr: 0, wd: '0, exp_err: 1'b1};
    // HI[7:1] must be ignored: FE contributes only bit 0 (=0) to the word.
    vecs[5] = '{nb: 5, b: {8'h01, 8'h00, 8'hAB, 8'hFE, 8'h56, 56'h0}, nwr: 1, wd: {9'h0AB, 18'h0}, exp_err: 1'b0};

    // Reset state
    repeat (10) @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_s_ready", 32'(s_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    s_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i, 1'b0);
      if (i == 0) begin
        // In RUN no byte may be taken even with valid held.
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("run_s_ready_low", 32'(s_ready), 32'd0);
        chk("run_cpu_rst_low", 32'(cpu_rst), 32'd0);
        s_valid = 1'b0;
      end
    end

    // Good frame with random valid gaps, started from RUN
    run_vec(vecs[0], 6, 1'b1);

    // Async reset while waiting for DATA_HI of word 1
    wq.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    s_valid = 1'b1;
    s_data  = 8'h01;
    #1 rst = 1'b1;
    #1;
    chk("async_s_ready", 32'(s_ready), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("async_imem_we", 32'(imem_we), 32'd0);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("async_write_count", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) chk("async_write0", 32'(wq[0]), 32'({10'd0, 9'h111}));
    run_vec(vecs[0], 7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
